// File: rtl/m_vpp_ocp_pkg.sv
// Shared definitions for the VPP lrbiu register-bus initiator: command encodings,
// initiator FSM states, the buffered command payload and VPP register addresses.
package m_vpp_ocp_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    MCMD_IDLE = 2'b00,
    MCMD_WR   = 2'b01,
    MCMD_RD   = 2'b10
  } mcmd_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CMD    = 2'd1,
    ST_RDWAIT = 2'd2,
    ST_RSP    = 2'd3
  } state_e;

  typedef struct packed {
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  localparam int unsigned CMD_W = $bits(cmd_t);

  // VPP register map, byte addresses on the lrbiu bus
  localparam logic [ADDR_W-1:0] VPP_REG_BASE = 32'h2010_0000;
  localparam logic [ADDR_W-1:0] REG_HSCTL    = VPP_REG_BASE + 32'h0000_0000;
  localparam logic [ADDR_W-1:0] REG_HSSTAT   = VPP_REG_BASE + 32'h0000_0004;
  localparam logic [ADDR_W-1:0] REG_HSIZE    = VPP_REG_BASE + 32'h0000_0008;
  localparam logic [ADDR_W-1:0] REG_HSCOEF   = VPP_REG_BASE + 32'h0000_0010;
  localparam logic [ADDR_W-1:0] REG_VSCTL    = VPP_REG_BASE + 32'h0000_0040;
  localparam logic [ADDR_W-1:0] REG_VSIZE    = VPP_REG_BASE + 32'h0000_0048;
  localparam logic [ADDR_W-1:0] REG_VS_Y     = VPP_REG_BASE + 32'h0000_0060;
  localparam logic [ADDR_W-1:0] REG_VS_UV    = VPP_REG_BASE + 32'h0000_0064;

  function automatic mcmd_e mcmd_of(input logic rd);
    return rd ? MCMD_RD : MCMD_WR;
  endfunction

endpackage

// File: rtl/m_vpp_sync_fifo.sv
// Single-clock FIFO with wrapping pointers and show-ahead read data.
module m_vpp_sync_fifo #(
  parameter int unsigned WIDTH = 65,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count_next_c
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign do_push      = push && !full;
  assign do_pop       = pop && !empty;
  assign full         = (count == CNT_W'(DEPTH));
  assign empty        = (count == '0);
  assign rdata        = mem[rd_ptr];
  assign count_next_c = count + CNT_W'(do_push) - CNT_W'(do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= PTR_W'(wr_ptr + PTR_W'(1));
      if (do_pop)  rd_ptr <= PTR_W'(rd_ptr + PTR_W'(1));
      count <= count_next_c;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/m_vpp_reg_master.sv
// lrbiu register-bus initiator: queues host commands and issues them one at a time,
// with read-data capture, accept timeout and a sticky first-error address record.
module m_vpp_reg_master
  import m_vpp_ocp_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        vpp_clk,
  input  logic        vpp_rst,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic        i_cmd_rd,
  input  logic [31:0] i_cmd_addr,
  input  logic [31:0] i_cmd_data,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_data,
  output logic        o_rsp_err,
  output logic [1:0]  o_lrbiu_mcmd,
  output logic [31:0] o_lrbiu_maddr,
  output logic [31:0] o_lrbiu_mdata,
  input  logic        i_lrbiu_scmdaccept,
  input  logic [31:0] i_lrbiu_sdata,
  output logic        o_busy,
  output logic        o_err,
  output logic [31:0] o_err_addr,
  input  logic        i_err_clr
);

  localparam int unsigned TO_W  = 16;
  localparam int unsigned LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  cmd_t             push_cmd;
  cmd_t             head;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count_next;

  state_e           state;
  logic             cur_rd;
  logic [TO_W-1:0]  to_cnt;
  logic [LAT_W-1:0] lat_cnt;
  logic             accept_c;
  logic             timeout_c;
  logic             idle_next_c;

  assign push_cmd = '{rd: i_cmd_rd, addr: i_cmd_addr, data: i_cmd_data};
  assign push     = i_cmd_valid && o_cmd_ready && !fifo_full;
  assign pop      = (state == ST_IDLE) && !fifo_empty;

  m_vpp_sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk          (vpp_clk),
    .rst          (vpp_rst),
    .push         (push),
    .pop          (pop),
    .wdata        (push_cmd),
    .rdata        (head),
    .full         (fifo_full),
    .empty        (fifo_empty),
    .count_next_c (fifo_count_next)
  );

  // Accept in the last allowed cycle takes priority over the abort.
  assign accept_c  = (state == ST_CMD) && i_lrbiu_scmdaccept;
  assign timeout_c = (state == ST_CMD) && !i_lrbiu_scmdaccept
                     && (to_cnt == TO_W'(TIMEOUT - 1));

  // FSM returns to IDLE next cycle: lets o_busy be registered without a lag.
  assign idle_next_c = ((state == ST_IDLE) && fifo_empty)
                    || ((state == ST_CMD) && !cur_rd && (accept_c || timeout_c))
                    || (state == ST_RSP);

  always_ff @(posedge vpp_clk) begin
    if (vpp_rst) begin
      state         <= ST_IDLE;
      cur_rd        <= 1'b0;
      to_cnt        <= '0;
      lat_cnt       <= '0;
      o_cmd_ready   <= 1'b1;
      o_rsp_valid   <= 1'b0;
      o_rsp_data    <= '0;
      o_rsp_err     <= 1'b0;
      o_lrbiu_mcmd  <= MCMD_IDLE;
      o_lrbiu_maddr <= '0;
      o_lrbiu_mdata <= '0;
      o_busy        <= 1'b0;
      o_err         <= 1'b0;
      o_err_addr    <= '0;
    end else begin
      o_rsp_valid <= 1'b0;
      o_cmd_ready <= (fifo_count_next != CNT_W'(DEPTH));
      o_busy      <= !idle_next_c || (fifo_count_next != '0);

      case (state)
        ST_IDLE: begin
          to_cnt <= '0;
          if (!fifo_empty) begin
            o_lrbiu_mcmd  <= mcmd_of(head.rd);
            o_lrbiu_maddr <= head.addr;
            o_lrbiu_mdata <= head.data;
            cur_rd        <= head.rd;
            state         <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (accept_c) begin
            o_lrbiu_mcmd <= MCMD_IDLE;
            if (cur_rd) begin
              lat_cnt <= LAT_W'(RD_LAT - 1);
              state   <= ST_RDWAIT;
            end else begin
              state <= ST_IDLE;
            end
          end else if (timeout_c) begin
            o_lrbiu_mcmd <= MCMD_IDLE;
            if (cur_rd) begin
              o_rsp_valid <= 1'b1;
              o_rsp_err   <= 1'b1;
              o_rsp_data  <= '0;
              state       <= ST_RSP;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            to_cnt <= TO_W'(to_cnt + TO_W'(1));
          end
        end
        ST_RDWAIT: begin
          if (lat_cnt == '0) begin
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= 1'b0;
            o_rsp_data  <= i_lrbiu_sdata;
            state       <= ST_RSP;
          end else begin
            lat_cnt <= LAT_W'(lat_cnt - LAT_W'(1));
          end
        end
        ST_RSP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase

      // Sticky error keeps the first failing address; a same-cycle timeout beats a clear.
      if (timeout_c) begin
        o_err <= 1'b1;
        if (!o_err || i_err_clr) o_err_addr <= o_lrbiu_maddr;
      end else if (i_err_clr) begin
        o_err      <= 1'b0;
        o_err_addr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_m_vpp_reg_master.sv
// Randomized bench for m_vpp_reg_master: register-file model, slave responder and
// a response scoreboard decoupled from stimulus.
module tb_m_vpp_reg_master;
  import m_vpp_ocp_pkg::*;

  localparam int DEPTH  = 4;
  localparam int RD_LAT = 1;
  localparam int TMO    = 8;
  localparam int NEVER  = 1000;

  logic        vpp_clk = 1'b0;
  logic        vpp_rst = 1'b1;
  logic        i_cmd_valid = 1'b0;
  logic        o_cmd_ready;
  logic        i_cmd_rd = 1'b0;
  logic [31:0] i_cmd_addr = '0;
  logic [31:0] i_cmd_data = '0;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_data;
  logic        o_rsp_err;
  logic [1:0]  o_lrbiu_mcmd;
  logic [31:0] o_lrbiu_maddr;
  logic [31:0] o_lrbiu_mdata;
  logic        i_lrbiu_scmdaccept = 1'b0;
  logic [31:0] i_lrbiu_sdata = '0;
  logic        o_busy;
  logic        o_err;
  logic [31:0] o_err_addr;
  logic        i_err_clr = 1'b0;

  m_vpp_reg_master #(
    .DEPTH   (DEPTH),
    .RD_LAT  (RD_LAT),
    .TIMEOUT (TMO)
  ) dut (
    .vpp_clk            (vpp_clk),
    .vpp_rst            (vpp_rst),
    .i_cmd_valid        (i_cmd_valid),
    .o_cmd_ready        (o_cmd_ready),
    .i_cmd_rd           (i_cmd_rd),
    .i_cmd_addr         (i_cmd_addr),
    .i_cmd_data         (i_cmd_data),
    .o_rsp_valid        (o_rsp_valid),
    .o_rsp_data         (o_rsp_data),
    .o_rsp_err          (o_rsp_err),
    .o_lrbiu_mcmd       (o_lrbiu_mcmd),
    .o_lrbiu_maddr      (o_lrbiu_maddr),
    .o_lrbiu_mdata      (o_lrbiu_mdata),
    .i_lrbiu_scmdaccept (i_lrbiu_scmdaccept),
    .i_lrbiu_sdata      (i_lrbiu_sdata),
    .o_busy             (o_busy),
    .o_err              (o_err),
    .o_err_addr         (o_err_addr),
    .i_err_clr          (i_err_clr)
  );

  always #5 vpp_clk = ~vpp_clk;

  int cyc = 0;
  always @(posedge vpp_clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;
  int n_rsp  = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, want, cyc);
    end
  endfunction

  // Register-file model (host view) and the slave's own storage
  logic [31:0] ref_mem   [logic [31:0]];
  logic [31:0] slave_mem [logic [31:0]];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] slave_rd(input logic [31:0] a);
    return slave_mem.exists(a) ? slave_mem[a] : init_val(a);
  endfunction

  cmd_t        exp_cmd_q [$];
  int          delay_q   [$];
  logic [32:0] exp_rsp_q [$];
  int          exp_cyc_q [$];

  // delay = index of the presentation cycle in which the slave accepts; >= TMO never accepts
  task automatic issue(input logic rd, input logic [31:0] addr, input logic [31:0] data,
                       input int delay, output int push_cyc);
    int   guard;
    cmd_t c;
    guard    = 0;
    push_cyc = -1;
    while (!o_cmd_ready) begin
      @(negedge vpp_clk);
      guard++;
      if (guard > 500) begin
        check("cmd_ready_wait", 32'(o_cmd_ready), 32'd1);
        return;
      end
    end
    i_cmd_valid = 1'b1;
    i_cmd_rd    = rd;
    i_cmd_addr  = addr;
    i_cmd_data  = data;
    push_cyc    = cyc;
    c.rd   = rd;
    c.addr = addr;
    c.data = data;
    exp_cmd_q.push_back(c);
    delay_q.push_back(delay);
    if (delay < TMO) begin
      if (rd) exp_rsp_q.push_back({1'b0, ref_rd(addr)});
      else    ref_mem[addr] = data;
    end else if (rd) begin
      exp_rsp_q.push_back({1'b1, 32'h0});
    end
    @(negedge vpp_clk);
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (o_busy || exp_cmd_q.size() != 0 || exp_rsp_q.size() != 0) begin
      @(negedge vpp_clk);
      g++;
      if (g > 2000) begin
        check("drain_timeout", 32'(o_busy), 32'd0);
        return;
      end
    end
    @(negedge vpp_clk);
  endtask

  // Slave responder: checks each presented command, accepts per its delay, returns read data
  logic        active = 1'b0;
  logic        expect_drop = 1'b0;
  cmd_t        cur;
  int          k = 0;
  int          d = 0;
  int          rd_cnt = 0;
  logic [31:0] rd_val = '0;

  always @(negedge vpp_clk) begin
    if (vpp_rst) begin
      active             = 1'b0;
      expect_drop        = 1'b0;
      rd_cnt             = 0;
      i_lrbiu_scmdaccept = 1'b1;
      i_lrbiu_sdata      = $urandom;
    end else begin
      if (rd_cnt > 0) begin
        rd_cnt--;
        i_lrbiu_sdata = (rd_cnt == 0) ? rd_val : $urandom;
      end else begin
        i_lrbiu_sdata = $urandom;
      end
      i_lrbiu_scmdaccept = 1'b0;
      if (expect_drop) begin
        check("mcmd_idle_after_end", 32'(o_lrbiu_mcmd), 32'd0);
        expect_drop = 1'b0;
        active      = 1'b0;
      end else if (active) begin
        check("mcmd_stable", 32'(o_lrbiu_mcmd), 32'(mcmd_of(cur.rd)));
        check("maddr_stable", o_lrbiu_maddr, cur.addr);
      end else if (o_lrbiu_mcmd != 2'b00) begin
        if (exp_cmd_q.size() == 0) begin
          check("unexpected_cmd", 32'(o_lrbiu_mcmd), 32'd0);
        end else begin
          cur    = exp_cmd_q.pop_front();
          d      = delay_q.pop_front();
          k      = 0;
          active = 1'b1;
          check("cmd_type", 32'(o_lrbiu_mcmd), 32'(mcmd_of(cur.rd)));
          check("cmd_addr", o_lrbiu_maddr, cur.addr);
          if (!cur.rd) check("cmd_data", o_lrbiu_mdata, cur.data);
        end
      end
      if (active && !expect_drop) begin
        if (k == d) begin
          i_lrbiu_scmdaccept = 1'b1;
          expect_drop        = 1'b1;
          if (cur.rd) begin
            rd_val = slave_rd(o_lrbiu_maddr);
            rd_cnt = RD_LAT;
            exp_cyc_q.push_back(cyc + RD_LAT + 1);
          end else begin
            slave_mem[o_lrbiu_maddr] = o_lrbiu_mdata;
          end
        end else if (k == TMO - 1) begin
          expect_drop = 1'b1;
          if (cur.rd) exp_cyc_q.push_back(cyc + 1);
        end
        k++;
      end
    end
  end

  // Response scoreboard
  logic [32:0] rsp_e;
  int          rsp_t;
  always @(negedge vpp_clk) begin
    if (!vpp_rst && o_rsp_valid) begin
      n_rsp++;
      if (exp_rsp_q.size() == 0 || exp_cyc_q.size() == 0) begin
        check("unexpected_rsp", 32'(o_rsp_valid), 32'd0);
      end else begin
        rsp_e = exp_rsp_q.pop_front();
        rsp_t = exp_cyc_q.pop_front();
        check("rsp_data", o_rsp_data, rsp_e[31:0]);
        check("rsp_err", 32'(o_rsp_err), 32'(rsp_e[32]));
        check("rsp_cycle", 32'(cyc), 32'(rsp_t));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int p, pc, r0;
    ref_mem[32'h2010_0004]   = 32'hA5A5_0003;
    slave_mem[32'h2010_0004] = 32'hA5A5_0003;

    repeat (3) @(negedge vpp_clk);
    vpp_rst = 1'b0;
    @(negedge vpp_clk);
    check("rst_cmd_ready", 32'(o_cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("rst_rsp_data", o_rsp_data, 32'd0);
    check("rst_rsp_err", 32'(o_rsp_err), 32'd0);
    check("rst_mcmd", 32'(o_lrbiu_mcmd), 32'd0);
    check("rst_maddr", o_lrbiu_maddr, 32'd0);
    check("rst_mdata", o_lrbiu_mdata, 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    check("rst_err_addr", o_err_addr, 32'd0);

    // Write accepted immediately: WR on the bus two cycles after the push
    issue(1'b0, 32'h2010_0000, 32'h1, 0, pc);
    @(negedge vpp_clk);
    check("wr_mcmd_c2", 32'(o_lrbiu_mcmd), 32'd1);
    check("wr_maddr_c2", o_lrbiu_maddr, 32'h2010_0000);
    check("wr_mdata_c2", o_lrbiu_mdata, 32'h1);
    @(negedge vpp_clk);
    check("wr_mcmd_c3", 32'(o_lrbiu_mcmd), 32'd0);
    check("wr_no_rsp", 32'(o_rsp_valid), 32'd0);
    check("wr_busy_c3", 32'(o_busy), 32'd0);

    // Read accepted after 3 stalled cycles
    r0 = n_rsp;
    issue(1'b1, 32'h2010_0004, 32'h0, 3, pc);
    wait_idle();
    check("rd_rsp_count", 32'(n_rsp), 32'(r0 + 1));

    // Back-to-back writes with the slave stalled: FIFO plus the command on the bus fill up
    p = cyc;
    issue(1'b0, 32'h2010_0010, $urandom, 6, pc);
    for (int i = 1; i < 5; i++) issue(1'b0, 32'h2010_0010 + 32'(4 * i), $urandom, 0, pc);
    check("full_cmd_ready", 32'(o_cmd_ready), 32'd0);
    issue(1'b0, 32'h2010_0028, $urandom, 0, pc);
    check("full_push6_cycle", 32'(pc), 32'(p + 10));
    issue(1'b1, 32'h2010_0014, 32'h0, 1, pc);
    issue(1'b1, 32'h2010_0028, 32'h0, 2, pc);
    wait_idle();

    // Timeouts and the sticky error record
    check("err_before_to", 32'(o_err), 32'd0);
    issue(1'b1, 32'h2010_0064, 32'h0, NEVER, pc);
    wait_idle();
    check("to_err", 32'(o_err), 32'd1);
    check("to_err_addr", o_err_addr, 32'h2010_0064);
    issue(1'b0, 32'h2010_0068, 32'h5, NEVER, pc);
    wait_idle();
    check("to2_err", 32'(o_err), 32'd1);
    check("to2_err_addr_kept", o_err_addr, 32'h2010_0064);
    i_err_clr = 1'b1;
    @(negedge vpp_clk);
    i_err_clr = 1'b0;
    check("clr_err", 32'(o_err), 32'd0);
    check("clr_err_addr", o_err_addr, 32'd0);

    // Accept in the last allowed cycle completes normally
    issue(1'b0, 32'h2010_0070, 32'h1234_5678, TMO - 1, pc);
    issue(1'b1, 32'h2010_0070, 32'h0, TMO - 1, pc);
    wait_idle();
    check("edge_no_err", 32'(o_err), 32'd0);

    // Random traffic against the register-file model
    for (int i = 0; i < 60; i++) begin
      int sel, dly;
      sel = $urandom_range(0, 9);
      if (sel < 6)      dly = $urandom_range(0, 2);
      else if (sel < 9) dly = $urandom_range(3, TMO - 1);
      else              dly = TMO + $urandom_range(0, 3);
      issue(1'($urandom_range(0, 1)), 32'h2010_0000 + 32'(4 * $urandom_range(0, 7)),
            $urandom, dly, pc);
      repeat ($urandom_range(0, 2)) @(negedge vpp_clk);
    end
    wait_idle();

    // Reset while a read is in RDWAIT and two writes are queued
    p = cyc;
    issue(1'b1, 32'h2010_0004, 32'h0, 0, pc);
    issue(1'b0, 32'h2010_0F00, $urandom, 0, pc);
    issue(1'b0, 32'h2010_0F04, $urandom, 0, pc);
    check("rdwait_reached", 32'(cyc), 32'(p + 3));
    r0 = n_rsp;
    vpp_rst = 1'b1;
    @(negedge vpp_clk);
    check("rst2_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("rst2_busy", 32'(o_busy), 32'd0);
    check("rst2_mcmd", 32'(o_lrbiu_mcmd), 32'd0);
    check("rst2_cmd_ready", 32'(o_cmd_ready), 32'd1);
    exp_cmd_q.delete();
    delay_q.delete();
    exp_rsp_q.delete();
    exp_cyc_q.delete();
    ref_mem.delete(32'h2010_0F00);
    ref_mem.delete(32'h2010_0F04);
    @(negedge vpp_clk);
    vpp_rst = 1'b0;
    repeat (6) @(negedge vpp_clk);
    check("rst2_rsp_dropped", 32'(n_rsp), 32'(r0));
    check("rst2_idle_busy", 32'(o_busy), 32'd0);
    issue(1'b1, 32'h2010_0F00, 32'h0, 0, pc);
    issue(1'b1, 32'h2010_0F04, 32'h0, 1, pc);
    wait_idle();

    check("end_cmd_q_empty", 32'(exp_cmd_q.size()), 32'd0);
    check("end_rsp_q_empty", 32'(exp_rsp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/m_vpp_reg_master.md
# m_vpp_reg_master

OCP-style register initiator that drives the `lrbiu` register bus into the VPP register manager. It buffers host register commands (write or read, address, data) in a small FIFO and issues them one at a time as OCP master commands. It waits for command accept, captures read data after a fixed latency, and returns read responses. It also enforces an accept timeout and keeps a sticky error record. It sits between the host/sequencer side and the VPP register manager's slave port.

## Interface
- `DEPTH`, 4: command FIFO entries (power of two, ≥2).
- `RD_LAT`, 1: cycles from read-accept cycle to valid `i_lrbiu_sdata` (≥1).
- `TIMEOUT`, 255: max cycles a command is presented without accept (≥1, ≤ 2^16−1).

Ports:
- `vpp_clk` in 1: clock, all logic on rising edge.
- `vpp_rst` in 1: reset, synchronous, active-high.
- `i_cmd_valid` in 1: host command valid.
- `o_cmd_ready` in 1: out; FIFO not full.
- `i_cmd_rd` in 1: 1 = read, 0 = write.
- `i_cmd_addr` in 32: register byte address.
- `i_cmd_data` in 32: write data (ignored for reads).
- `o_rsp_valid` out 1: one-cycle read response strobe.
- `o_rsp_data` out 32: read data, 0 on error.
- `o_rsp_err` out 1: response is a timed-out read.
- `o_lrbiu_mcmd` out 2: 2'b00 IDLE, 2'b01 WR, 2'b10 RD.
- `o_lrbiu_maddr` out 32: command address.
- `o_lrbiu_mdata` out 32: write data.
- `i_lrbiu_scmdaccept` in 1: slave accepts current command.
- `i_lrbiu_sdata` in 32: slave read data.
- `o_busy` out 1: FIFO non-empty or FSM not IDLE.
- `o_err` out 1: sticky, set on any timeout.
- `o_err_addr` out 32: address of first timed-out command since last clear.
- `i_err_clr` in 1: clears `o_err`/`o_err_addr`; a timeout in the same cycle wins.

## Operation
- Push occurs when `i_cmd_valid && o_cmd_ready`.
  - Push and pop in the same cycle are legal when the FIFO is non-empty.
  - No push is possible when full.
- FSM states: IDLE, CMD, RDWAIT, RSP.
  - IDLE: if the FIFO is non-empty, pop and load `mcmd`/`maddr`/`mdata` registers, then go to CMD. Timeout counter is cleared.
  - CMD: `mcmd` is held stable until accept.
    - Write accepted (`i_lrbiu_scmdaccept=1`): go to IDLE.
    - Read accepted: go to RDWAIT with latency counter = RD_LAT−1.
    - If counter reaches TIMEOUT−1 without accept: abort.
      - Set `o_err`; capture `o_err_addr` if `o_err` was 0.
      - A write goes to IDLE.
      - A read goes to RSP with the error flag set.
    - Accept in the final allowed cycle wins over timeout.
  - RDWAIT: count down; at 0 capture `i_lrbiu_sdata`, go to RSP. This is a pass-through for RD_LAT=1.
  - RSP: `o_rsp_valid=1` for exactly one cycle, then IDLE. There is no response backpressure.
- `o_lrbiu_mcmd` returns to 2'b00 in the cycle after accept or abort.
  - `maddr`/`mdata` hold their last values and are don't-care while IDLE.
- Commands are strictly in order; only one is outstanding.

## Timing
- All outputs are registered.
- Reset values: `o_cmd_ready`=1, `o_rsp_valid`=0, `o_rsp_data`=0, `o_rsp_err`=0, `o_lrbiu_mcmd`=2'b00, `o_lrbiu_maddr`=0, `o_lrbiu_mdata`=0, `o_busy`=0, `o_err`=0, `o_err_addr`=0.
- Write, immediately accepted:
  - push at cycle 0;
  - `mcmd`=WR at cycle 2;
  - accepted at cycle 2;
  - IDLE at cycle 3.
  - Peak throughput is one command per 2 cycles.
- Read with accept at cycle T:
  - `i_lrbiu_sdata` sampled at T+RD_LAT;
  - `o_rsp_valid` at T+RD_LAT+1.
- Timeout: a command first presented at cycle C with no accept is aborted. `mcmd`=IDLE at C+TIMEOUT.
- `o_cmd_ready` deasserts the cycle after the push that fills the FIFO. It reasserts the cycle after a pop from full.
- Reset mid-operation (any state): next edge gives reset values.
  - FIFO is flushed.
  - Pending read response is dropped.
  - An accept arriving in the reset cycle is ignored.

## Structure
- Shared package `m_vpp_ocp_pkg`:
  - MCMD encodings (IDLE/WR/RD);
  - FSM state encoding;
  - register address constants (HSCTL…VS_UV) for benches and host sequencers.
- One sub-module: `m_vpp_sync_fifo` (parameters WIDTH=65, DEPTH), same clock/reset. It has pointer wrap-around and full/empty flags, with count width log2(DEPTH)+1.

## Test plan
- After reset, push WR 32'h2010_0000/32'h1 with slave accepting immediately -> `mcmd`=01, addr/data correct at cycle 2, `mcmd`=00 at cycle 3, no `o_rsp_valid`.
- Push RD 32'h2010_0004 with RD_LAT=1, slave accepting after 3 cycles, returning 32'hA5A5_0003 -> one `o_rsp_valid` with that data and `o_rsp_err`=0, in the cycle after sdata sampling.
- Push 6 writes back-to-back with DEPTH=4 and accept stalled -> `o_cmd_ready` low after 5 accepted pushes (4 FIFO + 1 in CMD). All 6 issue in order once accept resumes.
- TIMEOUT=8, RD to 32'h2010_0064, never accepted -> `mcmd` IDLE 8 cycles after presentation; `o_rsp_valid`,`o_rsp_err`=1, data 0; `o_err`=1, `o_err_addr`=32'h2010_0064. A second timeout does not overwrite the address. `i_err_clr` clears it.
- Accept exactly on the TIMEOUT-th cycle -> normal completion, `o_err` stays 0.
- Assert `vpp_rst` during RDWAIT with 2 commands queued -> no response, `o_busy`=0, `mcmd`=00, FIFO empty next cycle.
